// File: rtl/lr3_pkg.sv
// Shared types and constants for the lr3 stopwatch time base.
// Lap/freeze support is built only when LR3_STOPWATCH_LAP_EN is defined.
package lr3_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_PAUSE = 2'd2
  } state_t;

  localparam int          BCD_W             = 4;
  localparam logic [3:0]  BCD_MAX           = 4'd9;
  localparam int          TICKS_PER_LSB_DEF = 10;

endpackage

// File: rtl/lr3_bcd_digit.sv
// One BCD counter digit with a ripple-enable carry out.
// The carry is combinational, so a full digit chain resolves in one cycle.
module lr3_bcd_digit
  import lr3_pkg::*;
#(
  parameter logic [BCD_W-1:0] MAX = BCD_MAX
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_clr,
  input  logic             i_en,
  output logic [BCD_W-1:0] o_q,
  output logic             o_carry
);

  logic [BCD_W-1:0] r_q;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_q <= '0;
    end else if (i_clr) begin
      r_q <= '0;
    end else if (i_en) begin
      r_q <= (r_q == MAX) ? '0 : r_q + 1'b1;
    end
  end

  assign o_q     = r_q;
  assign o_carry = i_en && (r_q == MAX);

endmodule

// File: rtl/lr3_stopwatch.sv
// Stopwatch time base: prescales 1 ms CE pulses into 10 ms steps and counts BCD 00.00..59.99.
// Optional lap freeze of the displayed value is enabled with LR3_STOPWATCH_LAP_EN.
module lr3_stopwatch
  import lr3_pkg::*;
#(
  parameter int TICKS_PER_LSB = TICKS_PER_LSB_DEF,
  parameter int SEC_TENS_MAX  = 5
) (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic        i_ce,
  input  logic        i_start_stop,
  input  logic        i_clear,
`ifdef LR3_STOPWATCH_LAP_EN
  input  logic        i_lap,
`endif
  output logic [15:0] o_digits,
  output logic        o_running,
  output logic        o_ovf
);

  localparam int            PW         = (TICKS_PER_LSB > 1) ? $clog2(TICKS_PER_LSB) : 1;
  localparam logic [PW-1:0] PRESC_LAST = PW'(TICKS_PER_LSB - 1);

  state_t           r_state;
  state_t           w_state_nxt;
  logic             w_running;
  logic [PW-1:0]    r_presc;
  logic             r_ovf;
  logic             w_tick;
  logic             w_step;
  logic [BCD_W-1:0] w_hund, w_tenth, w_sec_u, w_sec_t;
  logic             w_c_hund, w_c_tenth, w_c_sec_u, w_c_sec_t;
  logic [15:0]      w_live;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // CLEAR wins over START_STOP arriving in the same cycle.
  always_comb begin
    w_state_nxt = r_state;
    w_running   = (r_state == ST_RUN);
    if (i_clear) begin
      w_state_nxt = ST_IDLE;
    end else if (i_start_stop) begin
      case (r_state)
        ST_IDLE:  w_state_nxt = ST_RUN;
        ST_RUN:   w_state_nxt = ST_PAUSE;
        ST_PAUSE: w_state_nxt = ST_RUN;
        default:  w_state_nxt = ST_IDLE;
      endcase
    end
  end

  // CE is judged against the registered state, so a tick coincident with a pause still counts.
  assign w_tick = (r_state == ST_RUN) && i_ce;
  assign w_step = w_tick && (r_presc == PRESC_LAST);

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_presc <= '0;
    end else if (i_clear) begin
      r_presc <= '0;
    end else if (w_tick) begin
      r_presc <= w_step ? '0 : r_presc + 1'b1;
    end
  end

  lr3_bcd_digit #(.MAX(BCD_MAX)) u_hund (
    .i_clk(i_clk), .i_rst_n(i_rst_n), .i_clr(i_clear), .i_en(w_step),
    .o_q(w_hund), .o_carry(w_c_hund)
  );

  lr3_bcd_digit #(.MAX(BCD_MAX)) u_tenth (
    .i_clk(i_clk), .i_rst_n(i_rst_n), .i_clr(i_clear), .i_en(w_c_hund),
    .o_q(w_tenth), .o_carry(w_c_tenth)
  );

  lr3_bcd_digit #(.MAX(BCD_MAX)) u_sec_u (
    .i_clk(i_clk), .i_rst_n(i_rst_n), .i_clr(i_clear), .i_en(w_c_tenth),
    .o_q(w_sec_u), .o_carry(w_c_sec_u)
  );

  lr3_bcd_digit #(.MAX(BCD_W'(SEC_TENS_MAX))) u_sec_t (
    .i_clk(i_clk), .i_rst_n(i_rst_n), .i_clr(i_clear), .i_en(w_c_sec_u),
    .o_q(w_sec_t), .o_carry(w_c_sec_t)
  );

  // Registered so the pulse lines up with the cycle showing 00.00.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_ovf <= 1'b0;
    end else begin
      r_ovf <= w_c_sec_t && !i_clear;
    end
  end

  assign w_live    = {w_sec_t, w_sec_u, w_tenth, w_hund};
  assign o_running = w_running;
  assign o_ovf     = r_ovf;

`ifdef LR3_STOPWATCH_LAP_EN
  logic        r_frozen;
  logic [15:0] r_lap_q;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_frozen <= 1'b0;
      r_lap_q  <= '0;
    end else if (i_clear) begin
      r_frozen <= 1'b0;
    end else if (i_lap && (r_state == ST_RUN)) begin
      r_frozen <= !r_frozen;
      if (!r_frozen) begin
        r_lap_q <= w_live;
      end
    end
  end

  assign o_digits = r_frozen ? r_lap_q : w_live;
`else
  assign o_digits = w_live;
`endif

endmodule

// File: tb/tb_lr3_stopwatch.sv
// Scoreboard bench for lr3_stopwatch: a hundredths-of-a-second integer model predicts each cycle.
// Define LR3_STOPWATCH_LAP_EN for both bench and RTL to exercise the lap freeze.
module tb_lr3_stopwatch;

  localparam int TICKS   = 10;
  localparam int STM     = 5;
  localparam int PERIOD  = (STM + 1) * 1000;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        ce = 1'b0;
  logic        ss = 1'b0;
  logic        clr = 1'b0;
  logic        lap = 1'b0;
  logic [15:0] digits;
  logic        running;
  logic        ovf;

  always #5 clk = ~clk;

  lr3_stopwatch #(.TICKS_PER_LSB(TICKS), .SEC_TENS_MAX(STM)) dut (
    .i_clk        (clk),
    .i_rst_n      (rst_n),
    .i_ce         (ce),
    .i_start_stop (ss),
    .i_clear      (clr),
`ifdef LR3_STOPWATCH_LAP_EN
    .i_lap        (lap),
`endif
    .o_digits     (digits),
    .o_running    (running),
    .o_ovf        (ovf)
  );

  typedef struct packed {
    logic [15:0] d;
    logic        r;
    logic        o;
  } exp_t;

  exp_t sb_q[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  // Reference model: elapsed hundredths, sub-step residue, run flag, lap freeze.
  int m_count, m_presc, m_lap_count;
  bit m_run, m_frozen, m_ovf;

  function automatic logic [15:0] to_bcd(input int c);
    return {4'(c / 1000), 4'((c / 100) % 10), 4'((c / 10) % 10), 4'(c % 10)};
  endfunction

  task automatic model_reset();
    m_count = 0; m_presc = 0; m_lap_count = 0;
    m_run = 0; m_frozen = 0; m_ovf = 0;
  endtask

  task automatic model_cycle(input bit c, input bit s, input bit k, input bit l);
    bit was_run;
    int count_before;
    was_run      = m_run;
    count_before = m_count;
    m_ovf        = 0;
    if (k) begin
      model_reset();
    end else begin
      if (was_run && c) begin
        m_presc++;
        if (m_presc == TICKS) begin
          m_presc = 0;
          m_count++;
          if (m_count == PERIOD) begin
            m_count = 0;
            m_ovf   = 1;
          end
        end
      end
`ifdef LR3_STOPWATCH_LAP_EN
      if (l && was_run) begin
        if (!m_frozen) begin
          m_frozen    = 1;
          m_lap_count = count_before;
        end else begin
          m_frozen = 0;
        end
      end
`endif
      if (s) m_run = !m_run;
    end
  endtask

  task automatic drive(input bit r, input bit c, input bit s, input bit k, input bit l);
    exp_t e;
    @(negedge clk);
    rst_n = !r; ce = c; ss = s; clr = k; lap = l;
    if (r) model_reset();
    else   model_cycle(c, s, k, l);
    e.d = m_frozen ? to_bcd(m_lap_count) : to_bcd(m_count);
    e.r = m_run;
    e.o = m_ovf;
    sb_q.push_back(e);
  endtask

  task automatic idle(input int n);
    repeat (n) drive(0, 0, 0, 0, 0);
  endtask

  task automatic ce_n(input int n, input int gap_max);
    repeat (n) begin
      idle($urandom_range(0, gap_max));
      drive(0, 1, 0, 0, 0);
    end
  endtask

  // Monitor: the DUT presents a result every cycle; compare it 1 time unit after the edge.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (sb_q.size() > 0) begin
        e = sb_q.pop_front();
        n_checks++;
        if (digits !== e.d) begin
          n_fail++;
          $display("FAIL digits t=%0t actual=%h required=%h", $time, digits, e.d);
        end
        n_checks++;
        if (running !== e.r) begin
          n_fail++;
          $display("FAIL running t=%0t actual=%b required=%b", $time, running, e.r);
        end
        n_checks++;
        if (ovf !== e.o) begin
          n_fail++;
          $display("FAIL ovf t=%0t actual=%b required=%b", $time, ovf, e.o);
        end
      end
    end
  end

  initial begin
    model_reset();
    repeat (3) drive(1, 1'($urandom_range(0, 1)), 0, 0, 0);
    ce_n(50, 2);

    drive(0, 0, 1, 0, 0);
    ce_n(1000, 1);

    drive(0, 0, 0, 1, 0);
    drive(0, 0, 1, 0, 0);
    ce_n(15, 2);
    drive(0, 0, 1, 0, 0);
    ce_n(100, 2);
    drive(0, 0, 1, 0, 0);
    ce_n(5, 2);
    idle(2);

    drive(0, 0, 0, 1, 0);
    drive(0, 0, 1, 0, 0);
    ce_n(9, 1);
    drive(0, 1, 1, 0, 0);
    ce_n(20, 1);
    drive(0, 1, 1, 0, 0);
    ce_n(12, 1);

`ifdef LR3_STOPWATCH_LAP_EN
    drive(0, 0, 0, 1, 0);
    drive(0, 0, 1, 0, 0);
    ce_n(200, 0);
    drive(0, 0, 0, 0, 1);
    ce_n(30, 1);
    drive(0, 0, 0, 0, 1);
    idle(3);
    drive(0, 0, 1, 0, 0);
    drive(0, 0, 0, 0, 1);
    drive(0, 0, 1, 0, 0);
    drive(0, 0, 0, 0, 1);
    ce_n(25, 0);
    drive(0, 0, 0, 1, 0);
    idle(2);
`endif

    for (int i = 0; i < 3000; i++) begin
      if (i == 1500) begin
        drive(1, 1, 0, 0, 0);
        drive(1, 0, 0, 0, 0);
      end
      drive(0, 1'($urandom_range(0, 1)),
               1'($urandom_range(0, 39) == 0),
               1'($urandom_range(0, 399) == 0),
               1'($urandom_range(0, 59) == 0));
    end

    drive(0, 0, 0, 1, 0);
    drive(0, 0, 1, 0, 0);
    ce_n(PERIOD * TICKS - 10, 0);
    idle(2);
    ce_n(10, 0);
    idle(3);
    ce_n(35, 0);
    drive(0, 1, 1, 1, 0);
    idle(3);

    repeat (3) @(negedge clk);
    n_checks++;
    if (sb_q.size() != 0) begin
      n_fail++;
      $display("FAIL scoreboard_drain actual=%0d required=0", sb_q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
